// File: rtl/div_result_queue_if.sv
// Handshake bundle between the upstream issuer, the fixed-latency divider outputs and the result consumer.
// DIV_RESULT_QUEUE_DBZ_EN adds the divisor input and the divide-by-zero flag.
interface div_result_queue_if #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int TAG_WIDTH      = 4,
    parameter int DEPTH          = 4
`ifdef DIV_RESULT_QUEUE_DBZ_EN
    ,
    parameter int DIVISOR_WIDTH  = 8
`endif
);
    logic                         issue_valid;
    logic                         issue_ready;
    logic [TAG_WIDTH-1:0]         issue_tag;
    logic [DIVIDEND_WIDTH-1:0]    div_quotient;
    logic [DIVIDEND_WIDTH-1:0]    div_remainder;
    logic                         out_valid;
    logic                         out_ready;
    logic [TAG_WIDTH-1:0]         out_tag;
    logic [DIVIDEND_WIDTH-1:0]    out_quotient;
    logic [DIVIDEND_WIDTH-1:0]    out_remainder;
    logic [$clog2(DEPTH+1)-1:0]   level;
`ifdef DIV_RESULT_QUEUE_DBZ_EN
    logic [DIVISOR_WIDTH-1:0]     issue_divisor;
    logic                         out_dbz;
`endif

    modport master (
        output issue_valid,
        input  issue_ready,
        output issue_tag,
        output div_quotient,
        output div_remainder,
        input  out_valid,
        output out_ready,
        input  out_tag,
        input  out_quotient,
        input  out_remainder,
`ifdef DIV_RESULT_QUEUE_DBZ_EN
        output issue_divisor,
        input  out_dbz,
`endif
        input  level
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  issue_tag,
        input  div_quotient,
        input  div_remainder,
        output out_valid,
        input  out_ready,
        output out_tag,
        output out_quotient,
        output out_remainder,
`ifdef DIV_RESULT_QUEUE_DBZ_EN
        input  issue_divisor,
        output out_dbz,
`endif
        output level
    );
endinterface

// File: rtl/div_result_queue.sv
// Valid/tag delay line, result FIFO and issue credits behind a non-stallable pipelined divider.
// DIV_RESULT_QUEUE_DBZ_EN carries a divide-by-zero flag alongside each result.
module div_result_queue #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int TAG_WIDTH      = 4,
    parameter int LATENCY        = 19,
    parameter int DEPTH          = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    div_result_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    generate
        if (LATENCY != DIVIDEND_WIDTH + 3) begin : g_bad_latency
            $error("LATENCY must equal DIVIDEND_WIDTH+3");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of two and at least 2");
        end
        if (DIVISOR_WIDTH < 1) begin : g_bad_divisor
            $error("DIVISOR_WIDTH must be at least 1");
        end
    endgenerate

    logic issue_ready;
    logic out_valid;
    logic accept;
    logic pop;
    logic capture;

    logic [CW-1:0]        credits_q, credits_d;
    logic [CW-1:0]        level_q, level_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LATENCY-1:0]   stage_valid_q, stage_valid_d;
    logic [TAG_WIDTH-1:0] stage_tag_q [LATENCY];
    logic [TAG_WIDTH-1:0] stage_tag_d [LATENCY];

    logic [TAG_WIDTH-1:0]      mem_tag [DEPTH];
    logic [DIVIDEND_WIDTH-1:0] mem_quo [DEPTH];
    logic [DIVIDEND_WIDTH-1:0] mem_rem [DEPTH];

    // Credits cover both in-flight and resident entries, so a capture always has a free slot.
    assign issue_ready = (credits_q != CW'(DEPTH));
    assign out_valid   = (level_q != '0);
    assign accept      = bus.issue_valid && issue_ready;
    assign pop         = out_valid && bus.out_ready;
    assign capture     = stage_valid_q[LATENCY-1];

    always_comb begin
        stage_valid_d  = {stage_valid_q[LATENCY-2:0], accept};
        stage_tag_d[0] = bus.issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            stage_tag_d[i] = stage_tag_q[i-1];
        end
    end

    always_comb begin
        credits_d = credits_q;
        level_d   = level_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (accept && !pop) begin
            credits_d = credits_q + CW'(1);
        end else if (!accept && pop) begin
            credits_d = credits_q - CW'(1);
        end
        if (capture && !pop) begin
            level_d = level_q + CW'(1);
        end else if (!capture && pop) begin
            level_d = level_q - CW'(1);
        end
        if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid_q <= '0;
            credits_q     <= '0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            credits_q     <= credits_d;
            level_q       <= level_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Tags and payload are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clock) begin
        stage_tag_q <= stage_tag_d;
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            mem_tag[wr_ptr_q] <= stage_tag_q[LATENCY-1];
            mem_quo[wr_ptr_q] <= bus.div_quotient;
            mem_rem[wr_ptr_q] <= bus.div_remainder;
        end
    end

    assign bus.issue_ready   = issue_ready;
    assign bus.out_valid     = out_valid;
    assign bus.level         = level_q;
    assign bus.out_tag       = out_valid ? mem_tag[rd_ptr_q] : '0;
    assign bus.out_quotient  = out_valid ? mem_quo[rd_ptr_q] : '0;
    assign bus.out_remainder = out_valid ? mem_rem[rd_ptr_q] : '0;

`ifdef DIV_RESULT_QUEUE_DBZ_EN
    logic               issue_dbz;
    logic [LATENCY-1:0] stage_dbz_q, stage_dbz_d;
    logic               mem_dbz [DEPTH];

    assign issue_dbz   = (bus.issue_divisor == '0);
    assign stage_dbz_d = {stage_dbz_q[LATENCY-2:0], issue_dbz};

    always_ff @(posedge clock) begin
        stage_dbz_q <= stage_dbz_d;
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            mem_dbz[wr_ptr_q] <= stage_dbz_q[LATENCY-1];
        end
    end

    assign bus.out_dbz = out_valid ? mem_dbz[rd_ptr_q] : 1'b0;
`endif
endmodule

// File: tb/tb_div_result_queue.sv
// Bench for div_result_queue: models the pipelined divider, checks against a queue-based reference.
// Build with DIV_RESULT_QUEUE_DBZ_EN defined to exercise the divide-by-zero flag.
module tb_div_result_queue;
    localparam int DW    = 16;
    localparam int VW    = 8;
    localparam int TW    = 4;
    localparam int LAT   = 19;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    div_result_queue_if #(.DIVIDEND_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

    div_result_queue #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TAG_WIDTH(TW), .LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Divider stand-in: result of the operands sampled at edge e appears on its outputs at edge e+LAT-1.
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] pipe_q [LAT];
    logic [DW-1:0] pipe_r [LAT];

    always @(posedge clock) begin
        if (divisor == '0) begin
            pipe_q[0] <= '1;
            pipe_r[0] <= dividend;
        end else begin
            pipe_q[0] <= dividend / DW'(divisor);
            pipe_r[0] <= dividend % DW'(divisor);
        end
        for (int k = 1; k < LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
            pipe_r[k] <= pipe_r[k-1];
        end
    end

    assign bus.div_quotient  = pipe_q[LAT-1];
    assign bus.div_remainder = pipe_r[LAT-1];
`ifdef DIV_RESULT_QUEUE_DBZ_EN
    assign bus.issue_divisor = divisor;
`endif

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
        int            due;
    } exp_t;

    typedef struct {
        logic [DW-1:0] dividend;
        logic [VW-1:0] divisor;
        logic [TW-1:0] tag;
        logic [DW-1:0] exp_q;
        logic [DW-1:0] exp_r;
    } vec_t;

    exp_t inflight[$];
    exp_t fifo[$];
    int   edge_n = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " out_valid"},   32'(bus.out_valid), 32'd0);
        chk({name, " level"},       32'(bus.level), 32'd0);
        chk({name, " issue_ready"}, 32'(bus.issue_ready), 32'd1);
        chk({name, " out_tag"},     32'(bus.out_tag), 32'd0);
        chk({name, " out_quot"},    32'(bus.out_quotient), 32'd0);
        chk({name, " out_rem"},     32'(bus.out_remainder), 32'd0);
`ifdef DIV_RESULT_QUEUE_DBZ_EN
        chk({name, " out_dbz"},     32'(bus.out_dbz), 32'd0);
`endif
    endtask

    task automatic check_outputs();
        int credits;
        credits = inflight.size() + fifo.size();
        chk("out_valid",   32'(bus.out_valid), 32'(fifo.size() > 0));
        chk("level",       32'(bus.level), 32'(fifo.size()));
        chk("issue_ready", 32'(bus.issue_ready), 32'(credits != DEPTH));
        if (fifo.size() > 0) begin
            chk("out_tag",  32'(bus.out_tag), 32'(fifo[0].tag));
            chk("out_quot", 32'(bus.out_quotient), 32'(fifo[0].q));
            chk("out_rem",  32'(bus.out_remainder), 32'(fifo[0].r));
`ifdef DIV_RESULT_QUEUE_DBZ_EN
            chk("out_dbz",  32'(bus.out_dbz), 32'(fifo[0].dbz));
`endif
        end
        if (!reset_n) chk_reset_outputs("in_reset");
    endtask

    // One clock: decide accept/pop from the model, advance the model at the edge, check at the falling edge.
    task automatic tick();
        bit   acc;
        bit   pp;
        exp_t e;
        acc   = reset_n && bus.issue_valid && ((inflight.size() + fifo.size()) != DEPTH);
        pp    = reset_n && (fifo.size() > 0) && bus.out_ready;
        e.tag = bus.issue_tag;
        e.dbz = (divisor == '0);
        e.q   = (divisor == '0) ? '1 : dividend / DW'(divisor);
        e.r   = (divisor == '0) ? dividend : dividend % DW'(divisor);
        e.due = 0;
        @(posedge clock);
        edge_n++;
        if (!reset_n) begin
            inflight.delete();
            fifo.delete();
        end else begin
            if (pp) void'(fifo.pop_front());
            while (inflight.size() > 0 && inflight[0].due == edge_n) begin
                chk("capture_room", 32'(fifo.size() < DEPTH), 32'd1);
                fifo.push_back(inflight.pop_front());
            end
            if (acc) begin
                e.due = edge_n + LAT;
                inflight.push_back(e);
            end
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input bit iv, input logic [TW-1:0] tag, input logic [DW-1:0] dvd,
                         input logic [VW-1:0] dvs, input bit ordy);
        bus.issue_valid = iv;
        bus.issue_tag   = tag;
        dividend        = dvd;
        divisor         = dvs;
        bus.out_ready   = ordy;
    endtask

    vec_t vecs[6];

    initial begin
        int            first_seen;
        int            accepts;
        int            seen_cnt;
        logic [TW-1:0] seen_tags[$];
        logic [DW-1:0] seen_quo[$];
        int            first_idx;
        int            last_idx;

        vecs[0] = '{16'd7,     8'd2,   4'd3,  16'd3,     16'd1};
        vecs[1] = '{16'd85,    8'd4,   4'd1,  16'd21,    16'd1};
        vecs[2] = '{16'd99,    8'd3,   4'd2,  16'd33,    16'd0};
        vecs[3] = '{16'hFFFF,  8'd1,   4'd15, 16'hFFFF,  16'd0};
        vecs[4] = '{16'd1000,  8'd255, 4'd7,  16'd3,     16'd235};
        vecs[5] = '{16'd5,     8'd9,   4'd0,  16'd0,     16'd5};

        reset_n = 1'b0;
        drive(1'b0, '0, '0, 8'd1, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Single requests: result visible exactly LAT edges after the accepting edge.
        for (int v = 0; v < 6; v++) begin
            drive(1'b1, vecs[v].tag, vecs[v].dividend, vecs[v].divisor, 1'b1);
            tick();
            drive(1'b0, '0, DW'($urandom), VW'($urandom), 1'b1);
            first_seen = -1;
            for (int n = 1; n <= 30 && first_seen < 0; n++) begin
                tick();
                if (bus.out_valid) begin
                    first_seen = n;
                    chk("single_tag",  32'(bus.out_tag), 32'(vecs[v].tag));
                    chk("single_quot", 32'(bus.out_quotient), 32'(vecs[v].exp_q));
                    chk("single_rem",  32'(bus.out_remainder), 32'(vecs[v].exp_r));
                end
            end
            chk("single_latency", 32'(first_seen), 32'(LAT));
            repeat (2) tick();
        end

        // Stream of four back-to-back requests.
        drive(1'b1, 4'd0, 16'd85,  8'd4, 1'b1); tick();
        drive(1'b1, 4'd1, 16'd99,  8'd3, 1'b1); tick();
        drive(1'b1, 4'd2, 16'd7,   8'd2, 1'b1); tick();
        drive(1'b1, 4'd3, 16'd200, 8'd7, 1'b1); tick();
        drive(1'b0, '0, '0, 8'd1, 1'b1);
        first_idx = -1;
        last_idx  = -1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.out_valid) begin
                seen_tags.push_back(bus.out_tag);
                seen_quo.push_back(bus.out_quotient);
                if (first_idx < 0) first_idx = n;
                last_idx = n;
            end
        end
        chk("stream_count", 32'(seen_tags.size()), 32'd4);
        chk("stream_span",  32'(last_idx - first_idx), 32'd3);
        if (seen_tags.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("stream_tag", 32'(seen_tags[i]), 32'(i));
            chk("stream_q0", 32'(seen_quo[0]), 32'd21);
            chk("stream_q1", 32'(seen_quo[1]), 32'd33);
            chk("stream_q3", 32'(seen_quo[3]), 32'd28);
        end

        // Backpressure: only DEPTH requests get in.
        accepts = 0;
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, TW'(8 + n), DW'(100 + n), 8'd5, 1'b0);
            if (bus.issue_valid && bus.issue_ready) accepts++;
            tick();
        end
        chk("bp_accepts", 32'(accepts), 32'(DEPTH));
        chk("bp_ready",   32'(bus.issue_ready), 32'd0);
        drive(1'b0, '0, '0, 8'd1, 1'b0);
        repeat (22) tick();
        chk("bp_level", 32'(bus.level), 32'(DEPTH));
        chk("bp_head",  32'(bus.out_tag), 32'd8);

        // Pop and issue together at full: the pop does not free a credit in the same cycle.
        drive(1'b1, 4'd12, 16'd77, 8'd7, 1'b1);
        chk("full_ready_blocked", 32'(bus.issue_ready), 32'd0);
        tick();
        drive(1'b1, 4'd12, 16'd77, 8'd7, 1'b0);
        chk("full_ready_free", 32'(bus.issue_ready), 32'd1);
        tick();
        chk("full_credit_back", 32'(bus.issue_ready), 32'd0);
        drive(1'b0, '0, '0, 8'd1, 1'b0);
        repeat (22) tick();
        chk("full_level", 32'(bus.level), 32'(DEPTH));
        drive(1'b0, '0, '0, 8'd1, 1'b1);
        repeat (6) tick();

        // Reset with three requests in flight discards them.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, TW'(n + 1), DW'(50 + n), 8'd3, 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 8'd1, 1'b1);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        inflight.delete();
        fifo.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        seen_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.out_valid) seen_cnt++;
        end
        chk("midreset_no_output", 32'(seen_cnt), 32'd0);
        chk("midreset_level",     32'(bus.level), 32'd0);
        chk("midreset_ready",     32'(bus.issue_ready), 32'd1);

`ifdef DIV_RESULT_QUEUE_DBZ_EN
        begin
            int dbz5;
            int dbz6;
            dbz5 = -1;
            dbz6 = -1;
            drive(1'b1, 4'd5, 16'd40, 8'd0, 1'b1); tick();
            drive(1'b1, 4'd6, 16'd40, 8'd1, 1'b1); tick();
            drive(1'b0, '0, '0, 8'd1, 1'b1);
            for (int n = 0; n < 30; n++) begin
                tick();
                if (bus.out_valid && bus.out_tag == 4'd5) dbz5 = int'(bus.out_dbz);
                if (bus.out_valid && bus.out_tag == 4'd6) dbz6 = int'(bus.out_dbz);
            end
            chk("dbz_zero_divisor", 32'(dbz5), 32'd1);
            chk("dbz_one_divisor",  32'(dbz6), 32'd0);
        end
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [VW-1:0] dvs;
            dvs = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
            drive($urandom_range(0, 3) != 0, TW'($urandom), DW'($urandom), dvs,
                  (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
        end
        drive(1'b0, '0, '0, 8'd1, 1'b1);
        repeat (30) tick();
        chk("drain_level", 32'(bus.level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div_result_queue.md
Name: div_result_queue

Overview:
- Sits directly downstream of the fixed-latency pipeline divider. The divider has no valid, tag or stall of its own.
- Tracks which divider input cycles carried real requests, using a valid/tag delay line matched to the divider latency.
- Captures the matching quotient/remainder into a result FIFO and presents them on a valid/ready output.
- Throttles upstream issue with a credit count, so a result leaving the non-stallable divider always has a FIFO slot.

Parameters:
- DIVIDEND_WIDTH, 16, width of divider quotient/remainder.
- DIVISOR_WIDTH, 8, width of divisor (used only with the optional feature).
- TAG_WIDTH, 4, opaque request tag carried alongside each division.
- LATENCY, 19, number of clock edges from the edge that samples an issue to the edge that updates the divider output register, plus one. Must equal DIVIDEND_WIDTH+3.
- DEPTH, 4, result FIFO entries. Must be a power of two and at least 2.

Ports:
- clock, input, 1, rising-edge clock shared with the divider.
- reset_n, input, 1, asynchronous active-low reset.
- issue_valid, input, 1, the upstream is presenting a request to the divider this cycle.
- issue_ready, output, 1, a credit is available; a request is accepted when issue_valid && issue_ready.
- issue_tag, input, TAG_WIDTH, tag of the presented request.
- div_quotient, input, DIVIDEND_WIDTH, divider quotient output.
- div_remainder, input, DIVIDEND_WIDTH, divider remainder output.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, the consumer takes the head entry when out_valid && out_ready.
- out_tag, output, TAG_WIDTH, head entry tag.
- out_quotient, output, DIVIDEND_WIDTH, head entry quotient.
- out_remainder, output, DIVIDEND_WIDTH, head entry remainder.
- level, output, $clog2(DEPTH+1), current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert assumed upstream) clears:
  - all delay-line valid bits;
  - FIFO read/write pointers and occupancy;
  - the credit counter.
- Values of all outputs during reset:
  - out_valid=0 and level=0;
  - out_tag, out_quotient and out_remainder are 0;
  - issue_ready=1.
- Delay line: LATENCY stages of {valid, tag}.
  - Stage 0 loads {accept, issue_tag} on each edge, where accept = issue_valid && issue_ready.
  - Stage k loads stage k-1 on each edge.
  - Non-accepted cycles shift in valid=0; the divider still computes garbage for them, and that garbage is ignored.
- Capture: on an edge where stage LATENCY-1 is valid, write {tag, div_quotient, div_remainder} into the FIFO at the write pointer and advance the pointer.
  - If a request's issue is sampled at edge e0, its result is written at edge e19 (default parameters).
  - out_valid rises after e19 if the FIFO was empty.
- Credit counter, width $clog2(DEPTH+1):
  - counts accepted requests that are in flight or still resident in the FIFO;
  - +1 on accept, -1 on pop (out_valid && out_ready), unchanged on both or neither;
  - issue_ready = (credits != DEPTH), combinational from the register only, with no combinational path from out_ready.
- FIFO:
  - first-word fall-through; out_* are driven from the entry at the read pointer;
  - pop advances the read pointer;
  - a capture and a pop on the same edge leave level unchanged;
  - a capture into a full FIFO cannot occur by construction; the bench asserts this.
- Wrap-around: pointers wrap modulo DEPTH; back-to-back accepts every cycle are supported up to DEPTH outstanding.
- Reset mid-operation: in-flight divider results are discarded, because the valid bits are cleared. The divider itself is not reset.

Optional Feature:
- Macro: DIV_RESULT_QUEUE_DBZ_EN.
- When defined:
  - adds input port issue_divisor [DIVISOR_WIDTH];
  - adds output port out_dbz [1];
  - the delay line and FIFO carry an extra bit, (issue_divisor == 0), sampled with accept;
  - out_dbz reflects it for the head entry and is 0 during reset;
  - quotient and remainder are still passed through unmodified.
- When undefined: neither port exists, and no extra storage is built.

Test Plan:
- Single request: accept dividend 7, divisor 2, tag 3 at edge e0 with out_ready=1 -> out_valid high only after e19, with out_quotient=3, out_remainder=1, out_tag=3. out_valid is low in every other cycle.
- Stream: tags 0..3 accepted on consecutive edges with out_ready=1 -> four consecutive out_valid cycles, tags in order 0,1,2,3, each with the correct quotient (e.g. 85/4 -> 21 rem 1; 99/3 -> 33 rem 0).
- Backpressure: DEPTH=4, out_ready=0, issue_valid held high for 8 cycles -> exactly 4 accepts, then issue_ready=0. level reaches 4 and holds; out_tag remains the first tag.
- Simultaneous events at full: with credits=4 and level=4, raise out_ready for one cycle with issue_valid=1 -> that cycle pops one and still has issue_ready=0. The next cycle accepts one, credits return to 4, and the eventual capture finds a free slot with no overflow.
- Reset mid-flight: accept 3 requests, assert reset_n=0 for 2 cycles at edge e5, release -> no out_valid ever appears for those requests, level=0, issue_ready=1.
- DBZ (macro defined): accept divisor 0, tag 5 -> the corresponding output has out_dbz=1, tag 5. A following divisor 1 request has out_dbz=0.
